// File: rtl/simon_pkg.sv
// Shared Simon Says types: segment encoding, playback FSM states and LED decode.
package simon_pkg;

   // Segment entry: 3'b0cc is colour cc, 3'b100 marks an empty slot.
   typedef logic [2:0] seg_t;

   localparam seg_t SEG_EMPTY = 3'b100;

   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
   // Galois taps for x^16 + x^14 + x^13 + x^11.
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      StIdle,
      StShow,
      StGap,
      StDone
   } play_state_e;

   // One-hot LED pattern for an entry; empty entries stay dark.
   function automatic logic [3:0] seg_to_onehot(seg_t seg);
      logic [3:0] oh;
      oh = 4'b0000;
      if (!seg[2]) begin
         unique case (seg[1:0])
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            default: oh = 4'b1000;
         endcase
      end
      return oh;
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero SEED falls back to the default seed.
module simon_lfsr
   import simon_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] q
);

   // An all-zero state would lock up the LFSR.
   localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

   logic [15:0] q_d, q_q;

   // Shift right, folding the taps in when a one falls out of bit 0.
   always_comb begin
      q_d = q_q >> 1;
      if (q_q[0]) begin
         q_d = q_d ^ LFSR_MASK;
      end
   end

   // State register, stepping every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= SeedEff;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/sequence_gen.sv
// Simon Says sequence builder and LED player.
// Optional feature macro: SEQ_NO_REPEAT_EN (no two consecutive entries share a colour).
module sequence_gen
   import simon_pkg::*;
#(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ON_CYCLES  = 25_000_000,
   parameter int unsigned OFF_CYCLES = 12_500_000,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  extend,
   input  logic                  clear,
   input  logic                  play_start,
   output logic [DEPTH-1:0][2:0] segment,
   output logic [5:0]            length,
   output logic                  full,
   output logic                  busy,
   output logic [3:0]            led,
   output logic                  play_done
);

   localparam int unsigned MaxCycles = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [CntW-1:0] OnLast  = CntW'(ON_CYCLES - 1);
   localparam logic [CntW-1:0] OffLast = CntW'(OFF_CYCLES - 1);

   logic [15:0] lfsr;
   logic        unused_lfsr;

   logic [DEPTH-1:0][2:0] seg_d, seg_q;
   logic [5:0]            len_d, len_q;
   logic                  full_d, full_q;
   logic                  busy_d, busy_q;
   logic [3:0]            led_d, led_q;
   logic                  done_d, done_q;
   play_state_e           state_d, state_q;
   logic [4:0]            idx_d, idx_q;
   logic [CntW-1:0]       cnt_d, cnt_q;

   logic [1:0] colour;
   logic       accept_ext;

   simon_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr)
   );

   // Only the low two bits pick a colour.
   assign unused_lfsr = ^lfsr[15:2];

   // Colour to store for an accepted extend, sampled from the live LFSR.
`ifdef SEQ_NO_REPEAT_EN
   logic [4:0] last_idx;
   always_comb begin
      colour   = lfsr[1:0];
      last_idx = 5'(len_q - 6'd1);
      if ((len_q != 6'd0) && (seg_q[last_idx][1:0] == colour)) begin
         colour = colour + 2'd1;
      end
   end
`else
   always_comb begin
      colour = lfsr[1:0];
   end
`endif

   // Next-state for the sequence store and playback FSM; clear wins over everything.
   always_comb begin
      seg_d      = seg_q;
      len_d      = len_q;
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      led_d      = led_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      accept_ext = extend && !busy_q && !full_q && !clear;

      if (clear) begin
         seg_d   = {DEPTH{SEG_EMPTY}};
         len_d   = 6'd0;
         state_d = StIdle;
         idx_d   = 5'd0;
         cnt_d   = '0;
         led_d   = 4'b0000;
         busy_d  = 1'b0;
      end else begin
         if (accept_ext) begin
            seg_d[len_q[4:0]] = {1'b0, colour};
            len_d             = len_q + 6'd1;
         end

         unique case (state_q)
            StIdle: begin
               // Uses the post-append length/entries so a same-cycle extend is played.
               if (play_start) begin
                  idx_d = 5'd0;
                  cnt_d = '0;
                  if (len_d == 6'd0) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StShow;
                     busy_d  = 1'b1;
                     led_d   = seg_to_onehot(seg_d[0]);
                  end
               end
            end
            StShow: begin
               if (cnt_q == OnLast) begin
                  state_d = StGap;
                  cnt_d   = '0;
                  led_d   = 4'b0000;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StGap: begin
               if (cnt_q == OffLast) begin
                  cnt_d = '0;
                  // Terminal compare in 6 bits so index 31 never wraps.
                  if (({1'b0, idx_q} + 6'd1) >= len_q) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     led_d   = 4'b0000;
                  end else begin
                     idx_d   = idx_q + 5'd1;
                     state_d = StShow;
                     led_d   = seg_to_onehot(seg_q[idx_q + 5'd1]);
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      full_d = (len_d == 6'd32);
   end

   // All state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q   <= {DEPTH{SEG_EMPTY}};
         len_q   <= 6'd0;
         full_q  <= 1'b0;
         busy_q  <= 1'b0;
         led_q   <= 4'b0000;
         done_q  <= 1'b0;
         state_q <= StIdle;
         idx_q   <= 5'd0;
         cnt_q   <= '0;
      end else begin
         seg_q   <= seg_d;
         len_q   <= len_d;
         full_q  <= full_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
         done_q  <= done_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign segment   = seg_q;
   assign length    = len_q;
   assign full      = full_q;
   assign busy      = busy_q;
   assign led       = led_q;
   assign play_done = done_q;

endmodule
